// File: rtl/spi_avalon_debug_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_avalon_debug_regs
// Purpose  : Avalon-MM debug register bank for the SPI controller. Exposes the
//            live data block size, a saturating rising-edge counter on the
//            argument-read-finished strobe, a capture FIFO of block sizes, a
//            control/status register and a scratch register, behind a
//            programmable wait-state handshake.
// Ports    : clock / reset            - clock, synchronous active-high reset
//            io_Avalon_*              - Avalon-MM slave (word addressed)
//            io_DataBlockSize         - current SPI data block size
//            io_ArgumentReadFinished  - level strobe, counted on rising edges
// Revision : 1.0 - initial release
// ============================================================================
module spi_avalon_debug_regs #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 3,
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] io_Avalon_address,
  input  logic                  io_Avalon_read,
  output logic [DATA_WIDTH-1:0] io_Avalon_readdata,
  input  logic                  io_Avalon_write,
  input  logic [DATA_WIDTH-1:0] io_Avalon_writedata,
  output logic                  io_Avalon_waitrequest,
  input  logic [31:0]           io_DataBlockSize,
  input  logic                  io_ArgumentReadFinished
);

  localparam int                    c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0]    c_ptr_last = c_ptr_w'(DEPTH - 1);
  localparam logic [7:0]            c_depth8   = 8'(DEPTH);
  localparam logic [15:0]           c_depth16  = 16'(DEPTH);
  localparam logic [31:0]           c_id       = 32'h5350_4442;
  localparam logic [ADDR_WIDTH-1:0] c_a_id     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_a_size   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_a_events = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] c_a_ctrl   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] c_a_pop    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] c_a_scr    = ADDR_WIDTH'(5);

  // State
  logic [3:0]            wait_q,    wait_d;
  logic                  hist_q,    hist_d;
  logic [31:0]           events_q,  events_d;
  logic                  cap_q,     cap_d;
  logic                  ovf_q,     ovf_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic [c_ptr_w-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [c_ptr_w-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [7:0]            level_q,   level_d;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_d [DEPTH];

  // Handshake / event decode
  logic w_req, w_stall, w_done, w_wr_done, w_rd_done, w_ctrl_wr, w_clear;
  logic w_edge, w_empty, w_full, w_pop, w_push_req, w_push, w_ovf_set;

  assign w_req = io_Avalon_read | io_Avalon_write;

  // A zero-wait configuration never stalls; otherwise stall until the counter
  // has seen WAIT_STATES request cycles.
  if (WAIT_STATES == 0) begin : g_no_wait
    assign w_stall = 1'b0;
  end else begin : g_wait
    assign w_stall = w_req && (wait_q < 4'(WAIT_STATES));
  end

  assign io_Avalon_waitrequest = w_stall;

  always_comb begin
    w_done     = w_req & ~w_stall;
    w_wr_done  = w_done & io_Avalon_write;
    // A simultaneous write wins; the read half of that cycle is discarded.
    w_rd_done  = w_done & io_Avalon_read & ~io_Avalon_write;
    w_ctrl_wr  = w_wr_done && (io_Avalon_address == c_a_ctrl);
    w_clear    = w_ctrl_wr & io_Avalon_writedata[2];
    w_edge     = io_ArgumentReadFinished & ~hist_q;
    w_empty    = (level_q == 8'd0);
    w_full     = (level_q == c_depth8);
    w_pop      = w_rd_done && (io_Avalon_address == c_a_pop) && !w_empty;
    // Clear beats a coincident edge: the sample is neither stored nor counted.
    w_push_req = w_edge & cap_q & ~w_clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_push     = w_push_req & (~w_full | w_pop);
    w_ovf_set  = w_push_req & w_full & ~w_pop;
  end

  always_comb begin
    wait_d    = (!w_req || w_done) ? 4'd0 : wait_q + 4'd1;
    hist_d    = io_ArgumentReadFinished;

    events_d  = events_q;
    if (w_clear) begin
      events_d = 32'd0;
    end else if (w_edge && (events_q != 32'hFFFF_FFFF)) begin
      events_d = events_q + 32'd1;
    end

    cap_d = cap_q;
    ovf_d = ovf_q;
    if (w_ctrl_wr) begin
      cap_d = io_Avalon_writedata[0];
      if (io_Avalon_writedata[1] | io_Avalon_writedata[2]) begin
        ovf_d = 1'b0;
      end
    end
    // A dropped sample in the same cycle as a clear-overflow write is kept.
    if (w_ovf_set) begin
      ovf_d = 1'b1;
    end

    scratch_d = scratch_q;
    if (w_wr_done && (io_Avalon_address == c_a_scr)) begin
      scratch_d = io_Avalon_writedata;
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (w_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = 8'd0;
    end else begin
      if (w_pop) begin
        rd_ptr_d = (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + c_ptr_w'(1);
      end
      if (w_push) begin
        mem_d[wr_ptr_q] = io_DataBlockSize;
        wr_ptr_d = (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + c_ptr_w'(1);
      end
      level_d = level_q + 8'(w_push) - 8'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q    <= 4'd0;
      hist_q    <= 1'b0;
      events_q  <= 32'd0;
      cap_q     <= 1'b1;
      ovf_q     <= 1'b0;
      scratch_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= 8'd0;
    end else begin
      wait_q    <= wait_d;
      hist_q    <= hist_d;
      events_q  <= events_d;
      cap_q     <= cap_d;
      ovf_q     <= ovf_d;
      scratch_q <= scratch_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible below the level count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    io_Avalon_readdata = '0;
    if (io_Avalon_read && !io_Avalon_write) begin
      case (io_Avalon_address)
        c_a_id:     io_Avalon_readdata = DATA_WIDTH'(c_id);
        c_a_size:   io_Avalon_readdata = DATA_WIDTH'(io_DataBlockSize);
        c_a_events: io_Avalon_readdata = DATA_WIDTH'(events_q);
        c_a_ctrl:   io_Avalon_readdata = DATA_WIDTH'({c_depth16, level_q, 6'b0, ovf_q, cap_q});
        c_a_pop:    io_Avalon_readdata = w_empty ? '0 : DATA_WIDTH'(mem_q[rd_ptr_q]);
        c_a_scr:    io_Avalon_readdata = scratch_q;
        default:    io_Avalon_readdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
